// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared types and defaults for the TDC measurement sequencer.
package tdc_meas_ctrl_pkg;

  localparam int DIG_OUT_DEFAULT = 8;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    MC_IDLE      = 3'd0,
    MC_ARM       = 3'd1,
    MC_WAIT_HIT  = 3'd2,
    MC_WAIT_DONE = 3'd3,
    MC_HOLD      = 3'd4
  } mc_state_t;

  // One counter serves both the timeout and the holdoff, so size it for the larger.
  function automatic int tmo_width(input int timeout, input int holdoff);
    int m;
    m = (timeout > holdoff) ? timeout : holdoff;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/tdc_coarse_cnt.sv
// Saturating up-counter with clear, enable and freeze; clear has priority.
module tdc_coarse_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         freeze,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !freeze && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arms the TDC, gates the hit, times the coarse
// interval and hands {coarse, fine} to a one-entry valid/ready output register.
module tdc_meas_ctrl
  import tdc_meas_ctrl_pkg::*;
#(
  parameter int DIG_OUT  = DIG_OUT_DEFAULT,
  parameter int COARSE_W = 12,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT,
  parameter int HOLDOFF  = 4,
  parameter int DROP_W   = 8
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iStart,
  input  logic                        iContinuous,
  input  logic                        iHitRaw,
  output logic                        oHitGate,
  output logic                        oTdcRst,
  input  logic                        iTdcDone,
  input  logic [DIG_OUT-1:0]          iTdcRes,
  output logic [COARSE_W+DIG_OUT-1:0] oData,
  output logic                        oValid,
  input  logic                        iReady,
  output logic                        oBusy,
  output logic                        oTimeout,
  output logic [DROP_W-1:0]           oDropCnt
);

  localparam int TMO_W = tmo_width(TIMEOUT, HOLDOFF);

  mc_state_t           state;
  logic                gate_en;
  logic                done_prev;
  logic [COARSE_W-1:0] coarse;
  logic [TMO_W-1:0]    tmo;
  logic                done_edge;
  logic                tmo_expired;
  logic                hold_over;
  logic                coarse_clr;
  logic                coarse_en;
  logic                tmo_clr;
  logic                tmo_en;

  // No register on the hit path: any added delay here would skew the fine measurement.
  assign oHitGate    = iHitRaw & gate_en;
  assign done_edge   = iTdcDone & ~done_prev;
  assign tmo_expired = (tmo == TMO_W'(TIMEOUT - 1));
  assign hold_over   = (tmo == TMO_W'(HOLDOFF - 1));

  always_comb begin
    coarse_clr = 1'b0;
    coarse_en  = 1'b0;
    tmo_clr    = 1'b0;
    tmo_en     = 1'b0;
    case (state)
      MC_ARM: begin
        coarse_clr = 1'b1;
        tmo_clr    = 1'b1;
      end
      MC_WAIT_HIT: begin
        coarse_en = 1'b1;
        tmo_en    = 1'b1;
        tmo_clr   = iHitRaw | tmo_expired;
      end
      MC_WAIT_DONE: begin
        tmo_en  = 1'b1;
        tmo_clr = done_edge | tmo_expired;
      end
      MC_HOLD: begin
        tmo_en  = 1'b1;
        tmo_clr = hold_over;
      end
      default: ;
    endcase
  end

  tdc_coarse_cnt #(.W(COARSE_W)) u_coarse (
    .clk    (iClk),
    .rst_n  (iRst),
    .clr    (coarse_clr),
    .en     (coarse_en),
    .freeze (iHitRaw),
    .count  (coarse)
  );

  tdc_coarse_cnt #(.W(TMO_W)) u_tmo (
    .clk    (iClk),
    .rst_n  (iRst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .freeze (1'b0),
    .count  (tmo)
  );

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state     <= MC_IDLE;
      gate_en   <= 1'b0;
      done_prev <= 1'b0;
      oTdcRst   <= 1'b0;
      oData     <= '0;
      oValid    <= 1'b0;
      oBusy     <= 1'b0;
      oTimeout  <= 1'b0;
      oDropCnt  <= '0;
    end else begin
      done_prev <= iTdcDone;
      oTdcRst   <= 1'b0;
      oTimeout  <= 1'b0;
      if (oValid && iReady) oValid <= 1'b0;
      case (state)
        MC_IDLE: begin
          if (iStart || iContinuous) begin
            state   <= MC_ARM;
            oTdcRst <= 1'b1;
            oBusy   <= 1'b1;
          end
        end
        MC_ARM: begin
          state   <= MC_WAIT_HIT;
          gate_en <= 1'b1;
        end
        MC_WAIT_HIT: begin
          if (iHitRaw) begin
            state   <= MC_WAIT_DONE;
            gate_en <= 1'b0;
          end else if (tmo_expired) begin
            state    <= MC_HOLD;
            gate_en  <= 1'b0;
            oTimeout <= 1'b1;
          end
        end
        MC_WAIT_DONE: begin
          if (done_edge) begin
            state <= MC_HOLD;
            // A result still waiting for the consumer wins; the new one is counted as lost.
            if (!oValid || iReady) begin
              oData  <= {coarse, iTdcRes};
              oValid <= 1'b1;
            end else if (oDropCnt != '1) begin
              oDropCnt <= oDropCnt + DROP_W'(1);
            end
          end else if (tmo_expired) begin
            state    <= MC_HOLD;
            oTimeout <= 1'b1;
          end
        end
        MC_HOLD: begin
          if (hold_over) begin
            if (iContinuous) begin
              state   <= MC_ARM;
              oTdcRst <= 1'b1;
            end else begin
              state <= MC_IDLE;
              oBusy <= 1'b0;
            end
          end
        end
        default: begin
          state   <= MC_IDLE;
          gate_en <= 1'b0;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Randomised bench for tdc_meas_ctrl against a cycle-timestamp reference model.
module tb_tdc_meas_ctrl;

  localparam int DIG_OUT  = 8;
  localparam int COARSE_W = 12;
  localparam int TIMEOUT  = 64;
  localparam int HOLDOFF  = 4;
  localparam int DROP_W   = 8;
  localparam int COARSE_MAX = (1 << COARSE_W) - 1;
  localparam int DROP_MAX   = (1 << DROP_W) - 1;

  localparam int PH_IDLE = 0;
  localparam int PH_ARM  = 1;
  localparam int PH_HIT  = 2;
  localparam int PH_DONE = 3;
  localparam int PH_HOLD = 4;

  logic clk = 1'b0;
  logic iRst, iStart, iContinuous, iHitRaw, iTdcDone, iReady;
  logic [DIG_OUT-1:0] iTdcRes;
  logic oHitGate, oTdcRst, oValid, oBusy, oTimeout;
  logic [COARSE_W+DIG_OUT-1:0] oData;
  logic [DROP_W-1:0] oDropCnt;

  int total_checks = 0;
  int passed_checks = 0;

  // Reference model: phases are timed by absolute cycle stamps.
  int  m_phase = PH_IDLE;
  int  now_cyc = 0;
  int  phase_entry = 0;
  int  elapsed;
  int  next_phase;
  bit  capture;
  bit  accept;
  bit  model_live = 0;
  bit  rand_ready = 0;
  logic [COARSE_W-1:0] coarse_cap;
  logic [COARSE_W+DIG_OUT-1:0] m_data;
  logic m_valid, m_timeout, m_tdcrst, m_busy, m_gate, m_prev_done;
  int  m_drop;

  tdc_meas_ctrl #(
    .DIG_OUT(DIG_OUT), .COARSE_W(COARSE_W), .TIMEOUT(TIMEOUT),
    .HOLDOFF(HOLDOFF), .DROP_W(DROP_W)
  ) dut (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iContinuous(iContinuous),
    .iHitRaw(iHitRaw), .oHitGate(oHitGate), .oTdcRst(oTdcRst),
    .iTdcDone(iTdcDone), .iTdcRes(iTdcRes), .oData(oData), .oValid(oValid),
    .iReady(iReady), .oBusy(oBusy), .oTimeout(oTimeout), .oDropCnt(oDropCnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!iRst) begin
      m_phase = PH_IDLE; phase_entry = now_cyc + 1;
      m_valid = 1'b0; m_data = '0; m_drop = 0; m_timeout = 1'b0;
      m_prev_done = 1'b0; coarse_cap = '0;
      model_live = 1;
    end else begin
      elapsed = now_cyc - phase_entry;
      next_phase = m_phase;
      capture = 0;
      m_timeout = 1'b0;
      accept = !m_valid || iReady;
      case (m_phase)
        PH_IDLE: if (iStart || iContinuous) next_phase = PH_ARM;
        PH_ARM:  next_phase = PH_HIT;
        PH_HIT: begin
          if (iHitRaw) begin
            next_phase = PH_DONE;
            coarse_cap = COARSE_W'((elapsed > COARSE_MAX) ? COARSE_MAX : elapsed);
          end else if (elapsed == TIMEOUT - 1) begin
            next_phase = PH_HOLD; m_timeout = 1'b1;
          end
        end
        PH_DONE: begin
          if (iTdcDone && !m_prev_done) begin
            next_phase = PH_HOLD; capture = 1;
          end else if (elapsed == TIMEOUT - 1) begin
            next_phase = PH_HOLD; m_timeout = 1'b1;
          end
        end
        default: if (elapsed == HOLDOFF - 1) next_phase = iContinuous ? PH_ARM : PH_IDLE;
      endcase
      if (capture && accept) begin
        m_data = {coarse_cap, iTdcRes};
        m_valid = 1'b1;
      end else begin
        if (capture) m_drop = (m_drop >= DROP_MAX) ? DROP_MAX : m_drop + 1;
        if (m_valid && iReady) m_valid = 1'b0;
      end
      if (next_phase != m_phase) phase_entry = now_cyc + 1;
      m_phase = next_phase;
      m_prev_done = iTdcDone;
    end
    m_tdcrst = (m_phase == PH_ARM);
    m_busy   = (m_phase != PH_IDLE);
    m_gate   = (m_phase == PH_HIT);
    now_cyc++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed_checks++;
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      check_output("valid",   32'(oValid),   32'(m_valid));
      check_output("data",    32'(oData),    32'(m_data));
      check_output("dropcnt", 32'(oDropCnt), 32'(m_drop));
      check_output("timeout", 32'(oTimeout), 32'(m_timeout));
      check_output("tdcrst",  32'(oTdcRst),  32'(m_tdcrst));
      check_output("busy",    32'(oBusy),    32'(m_busy));
      check_output("hitgate", 32'(oHitGate), 32'(m_gate & iHitRaw));
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #2;
      iReady = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_phase(input int p, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_phase == p) return;
      tick(1);
    end
    if (m_phase != p) begin
      total_checks++;
      $display("[TB] FAIL wait_phase: phase %0d expected %0d after %0d cycles", m_phase, p, budget);
    end
  endtask

  // One measurement from WAIT_HIT index 0: hit after hit_dly cycles, done edge after done_dly more.
  task automatic apply_stimulus(input int hit_dly, input int done_dly, input logic [DIG_OUT-1:0] res);
    wait_phase(PH_HIT, 40);
    if (hit_dly <= TIMEOUT - 1) begin
      tick(hit_dly);
      iHitRaw = 1'b1;
      tick(1);
      iHitRaw = 1'b0;
      tick(done_dly);
      iTdcRes = res;
      iTdcDone = 1'b1;
      tick(1);
      iTdcDone = 1'b0;
    end
  endtask

  task automatic single_shot(input int hit_dly, input int done_dly, input logic [DIG_OUT-1:0] res);
    wait_phase(PH_IDLE, 200);
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    apply_stimulus(hit_dly, done_dly, res);
    wait_phase(PH_IDLE, 200);
  endtask

  initial begin
    iRst = 1'b0; iStart = 1'b0; iContinuous = 1'b0; iHitRaw = 1'b0;
    iTdcDone = 1'b0; iReady = 1'b0; iTdcRes = '0;
    tick(2);
    check_output("reset_valid", 32'(oValid), 32'd0);
    check_output("reset_busy",  32'(oBusy),  32'd0);
    check_output("reset_drop",  32'(oDropCnt), 32'd0);
    iRst = 1'b1;
    tick(1);

    // Hit 10 cycles into WAIT_HIT, done edge 3 cycles later.
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    check_output("arm_tdcrst", 32'(oTdcRst), 32'd1);
    tick(1);
    check_output("arm_tdcrst_end", 32'(oTdcRst), 32'd0);
    tick(10);
    iHitRaw = 1'b1; iTdcRes = 8'h5A;
    tick(1);
    iHitRaw = 1'b0;
    tick(2);
    iTdcDone = 1'b1;
    tick(1);
    iTdcDone = 1'b0;
    check_output("first_valid", 32'(oValid), 32'd1);
    check_output("first_data",  32'(oData),  32'h00A5A);
    iReady = 1'b1;
    tick(1);
    check_output("first_drain", 32'(oValid), 32'd0);
    wait_phase(PH_IDLE, 20);

    // No hit: timeout pulse 64 cycles after WAIT_HIT entry; hit ignored outside WAIT_HIT.
    iReady = 1'b0;
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    tick(64);
    check_output("tmo_early", 32'(oTimeout), 32'd0);
    tick(1);
    check_output("tmo_pulse", 32'(oTimeout), 32'd1);
    check_output("tmo_novalid", 32'(oValid), 32'd0);
    iHitRaw = 1'b1;
    #1;
    check_output("hold_gate", 32'(oHitGate), 32'd0);
    tick(4);
    check_output("tmo_idle", 32'(oBusy), 32'd0);
    check_output("idle_gate", 32'(oHitGate), 32'd0);
    iHitRaw = 1'b0;

    // Continuous mode with a stalled consumer.
    iContinuous = 1'b1;
    apply_stimulus(5, 2, 8'h11);
    apply_stimulus(7, 1, 8'h22);
    apply_stimulus(3, 4, 8'h33);
    iContinuous = 1'b0;
    check_output("cont_drop", 32'(oDropCnt), 32'd2);
    check_output("cont_data", 32'(oData), 32'h00511);
    iReady = 1'b1;
    tick(1);
    check_output("cont_drain", 32'(oValid), 32'd0);
    wait_phase(PH_IDLE, 20);

    // Done level left high from before: only a fresh edge captures.
    iTdcDone = 1'b1;
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    wait_phase(PH_HIT, 5);
    tick(4);
    iHitRaw = 1'b1; iTdcRes = 8'hC3;
    tick(1);
    iHitRaw = 1'b0;
    tick(5);
    check_output("stale_done", 32'(oValid), 32'd0);
    iTdcDone = 1'b0;
    tick(1);
    iTdcDone = 1'b1;
    tick(1);
    iTdcDone = 1'b0;
    check_output("fresh_valid", 32'(oValid), 32'd1);
    check_output("fresh_data",  32'(oData),  32'h004C3);
    wait_phase(PH_IDLE, 20);

    // Reset during WAIT_DONE with a result pending.
    iReady = 1'b0;
    single_shot(2, 1, 8'h77);
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    wait_phase(PH_HIT, 5);
    tick(2);
    iHitRaw = 1'b1;
    tick(1);
    iHitRaw = 1'b0;
    tick(2);
    iRst = 1'b0;
    tick(1);
    check_output("rst_valid", 32'(oValid), 32'd0);
    check_output("rst_data",  32'(oData),  32'd0);
    check_output("rst_busy",  32'(oBusy),  32'd0);
    check_output("rst_drop",  32'(oDropCnt), 32'd0);
    iRst = 1'b1;
    tick(3);
    iTdcDone = 1'b1;
    tick(2);
    iTdcDone = 1'b0;
    check_output("rst_noresult", 32'(oValid), 32'd0);

    // Random single shots, including both timeout paths and the hit/timeout tie.
    rand_ready = 1;
    for (int k = 0; k < 30; k++) begin
      int hd, dd;
      hd = $urandom_range(0, 70);
      dd = $urandom_range(0, 66);
      if (k == 0) hd = TIMEOUT - 1;
      single_shot(hd, dd, 8'($urandom));
    end
    rand_ready = 0;
    #3;
    iReady = 1'b0;

    // Drop counter saturation.
    iContinuous = 1'b1;
    for (int k = 0; k < 260; k++) apply_stimulus(0, 0, 8'($urandom));
    iContinuous = 1'b0;
    wait_phase(PH_IDLE, 20);
    check_output("drop_sat", 32'(oDropCnt), 32'd255);

    $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
